sh7604_divu_arb: RTL

Two-port arbiter and sequencer for the SH7604 on-chip divide unit (DIVU). It accepts complete division jobs from two internal requesters, A and B, and grants them round-robin. For each granted job it drives the internal-bus (IBUS) master cycles that load the DIVU registers and start the divide, then waits out the divide and collects quotient, remainder and overflow. It sits between the requesters and the DIVU slave port on the CPU-side IBUS.

---
 rtl/sh7604_divu_arb.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sh7604_divu_arb.sv
// Round-robin two-requester front end for the SH7604 DIVU: loads operands over IBUS, waits out the divide, returns Q/R/OVF.
// Optional build macro DIVU_ARB_OVF_CLR_EN: clear DVCR.OVF (keeping OVFIE) after an overflowed divide.
module sh7604_divu_arb (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        A_REQ,
  input  logic        B_REQ,
  input  logic        A_DIV64,
  input  logic        B_DIV64,
  input  logic [31:0] A_DVSR,
  input  logic [31:0] B_DVSR,
  input  logic [31:0] A_DVDNTH,
  input  logic [31:0] B_DVDNTH,
  input  logic [31:0] A_DVDNTL,
  input  logic [31:0] B_DVDNTL,
  output logic        A_GNT,
  output logic        B_GNT,
  output logic        A_DONE,
  output logic        B_DONE,
  output logic [31:0] RES_Q,
  output logic [31:0] RES_R,
  output logic        RES_OVF,
  output logic [31:0] IBUS_A,
  output logic [31:0] IBUS_DO,
  input  logic [31:0] IBUS_DI,
  output logic [3:0]  IBUS_BA,
  output logic        IBUS_WE,
  output logic        IBUS_REQ,
  input  logic        IBUS_BUSY
);

  localparam logic [31:0] ADDR_DVSR   = 32'hFFFF_FF00;
  localparam logic [31:0] ADDR_DVDNT  = 32'hFFFF_FF04;
  localparam logic [31:0] ADDR_DVCR   = 32'hFFFF_FF08;
  localparam logic [31:0] ADDR_DVDNTH = 32'hFFFF_FF10;
  localparam logic [31:0] ADDR_DVDNTL = 32'hFFFF_FF14;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_DVSR, S_WR_DVDNTH, S_WR_DVDNTL,
    S_RD_Q, S_RD_R, S_RD_CR, S_CLR_CR, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic        ptr, ptr_nxt;
  logic        sel, sel_nxt;
  logic        div64, div64_nxt;
  logic [31:0] dvsr, dvsr_nxt;
  logic [31:0] dvh, dvh_nxt;
  logic [31:0] dvl, dvl_nxt;
  logic        ovfie, ovfie_nxt;
  logic        a_gnt_nxt, b_gnt_nxt, a_done_nxt, b_done_nxt;
  logic [31:0] res_q_nxt, res_r_nxt;
  logic        res_ovf_nxt;
  logic [31:0] ibus_a_nxt, ibus_do_nxt;
  logic        ibus_we_nxt, ibus_req_nxt;
  logic        win_b;
  logic        xfer;

  assign IBUS_BA = 4'b1111;
  assign xfer    = IBUS_REQ & ~IBUS_BUSY;

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    sel_nxt     = sel;
    div64_nxt   = div64;
    dvsr_nxt    = dvsr;
    dvh_nxt     = dvh;
    dvl_nxt     = dvl;
    ovfie_nxt   = ovfie;
    a_gnt_nxt   = 1'b0;
    b_gnt_nxt   = 1'b0;
    a_done_nxt  = 1'b0;
    b_done_nxt  = 1'b0;
    res_q_nxt   = RES_Q;
    res_r_nxt   = RES_R;
    res_ovf_nxt = RES_OVF;
    win_b       = B_REQ & (~A_REQ | ptr);

    case (state)
      S_IDLE: begin
        if (A_REQ | B_REQ) begin
          sel_nxt   = win_b;
          div64_nxt = win_b ? B_DIV64  : A_DIV64;
          dvsr_nxt  = win_b ? B_DVSR   : A_DVSR;
          dvh_nxt   = win_b ? B_DVDNTH : A_DVDNTH;
          dvl_nxt   = win_b ? B_DVDNTL : A_DVDNTL;
          a_gnt_nxt = ~win_b;
          b_gnt_nxt = win_b;
          state_nxt = S_WR_DVSR;
        end
      end
      S_WR_DVSR:   if (xfer) state_nxt = div64 ? S_WR_DVDNTH : S_WR_DVDNTL;
      S_WR_DVDNTH: if (xfer) state_nxt = S_WR_DVDNTL;
      S_WR_DVDNTL: if (xfer) state_nxt = S_RD_Q;
      S_RD_Q: begin
        if (xfer) begin
          res_q_nxt = IBUS_DI;
          state_nxt = S_RD_R;
        end
      end
      S_RD_R: begin
        if (xfer) begin
          res_r_nxt = IBUS_DI;
          state_nxt = S_RD_CR;
        end
      end
      S_RD_CR: begin
        if (xfer) begin
          res_ovf_nxt = IBUS_DI[0];
          ovfie_nxt   = IBUS_DI[1];
`ifdef DIVU_ARB_OVF_CLR_EN
          state_nxt   = IBUS_DI[0] ? S_CLR_CR : S_DONE;
`else
          state_nxt   = S_DONE;
`endif
        end
      end
      S_CLR_CR: if (xfer) state_nxt = S_DONE;
      S_DONE: begin
        a_done_nxt = ~sel;
        b_done_nxt = sel;
        ptr_nxt    = ~sel;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Bus outputs are registered from the state being entered, so each cycle is presented one edge ahead.
    ibus_req_nxt = 1'b1;
    ibus_we_nxt  = 1'b0;
    ibus_a_nxt   = 32'h0;
    ibus_do_nxt  = 32'h0;
    case (state_nxt)
      S_WR_DVSR: begin
        ibus_we_nxt = 1'b1;
        ibus_a_nxt  = ADDR_DVSR;
        ibus_do_nxt = dvsr_nxt;
      end
      S_WR_DVDNTH: begin
        ibus_we_nxt = 1'b1;
        ibus_a_nxt  = ADDR_DVDNTH;
        ibus_do_nxt = dvh_nxt;
      end
      S_WR_DVDNTL: begin
        ibus_we_nxt = 1'b1;
        ibus_a_nxt  = div64_nxt ? ADDR_DVDNTL : ADDR_DVDNT;
        ibus_do_nxt = dvl_nxt;
      end
      S_RD_Q:  ibus_a_nxt = ADDR_DVDNTL;
      S_RD_R:  ibus_a_nxt = ADDR_DVDNTH;
      S_RD_CR: ibus_a_nxt = ADDR_DVCR;
      S_CLR_CR: begin
        ibus_we_nxt = 1'b1;
        ibus_a_nxt  = ADDR_DVCR;
        ibus_do_nxt = {30'b0, ovfie_nxt, 1'b0};
      end
      default: ibus_req_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      ptr      <= 1'b0;
      sel      <= 1'b0;
      div64    <= 1'b0;
      dvsr     <= 32'h0;
      dvh      <= 32'h0;
      dvl      <= 32'h0;
      ovfie    <= 1'b0;
      A_GNT    <= 1'b0;
      B_GNT    <= 1'b0;
      A_DONE   <= 1'b0;
      B_DONE   <= 1'b0;
      RES_Q    <= 32'h0;
      RES_R    <= 32'h0;
      RES_OVF  <= 1'b0;
      IBUS_A   <= 32'h0;
      IBUS_DO  <= 32'h0;
      IBUS_WE  <= 1'b0;
      IBUS_REQ <= 1'b0;
    end else if (CE_R) begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      sel      <= sel_nxt;
      div64    <= div64_nxt;
      dvsr     <= dvsr_nxt;
      dvh      <= dvh_nxt;
      dvl      <= dvl_nxt;
      ovfie    <= ovfie_nxt;
      A_GNT    <= a_gnt_nxt;
      B_GNT    <= b_gnt_nxt;
      A_DONE   <= a_done_nxt;
      B_DONE   <= b_done_nxt;
      RES_Q    <= res_q_nxt;
      RES_R    <= res_r_nxt;
      RES_OVF  <= res_ovf_nxt;
      IBUS_A   <= ibus_a_nxt;
      IBUS_DO  <= ibus_do_nxt;
      IBUS_WE  <= ibus_we_nxt;
      IBUS_REQ <= ibus_req_nxt;
    end
  end

endmodule
